// File: rtl/mc_control_pkg.sv
// -----------------------------------------------------------------------------
// mc_control_pkg
// Shared definitions for the multi-cycle MIPS-subset control unit:
//   - FSM state encoding (IF=0, ID=1, EX=2, MEM=3, WB=4)
//   - instruction classes produced by mc_decode
//   - primary opcode and R-type func field constants
//   - ALUctr operation encoding
// -----------------------------------------------------------------------------
package mc_control_pkg;

  // FSM states; the numeric values are visible on the debug state port.
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  // Instruction classes. All I-type ALU ops (ori/addiu/addi) share one class;
  // their differences are carried by ALUctr and ExtOp from the decoder.
  typedef enum logic [2:0] {
    C_ILL   = 3'd0,
    C_RTYPE = 3'd1,
    C_IALU  = 3'd2,
    C_LW    = 3'd3,
    C_SW    = 3'd4,
    C_BEQ   = 3'd5,
    C_J     = 3'd6
  } cls_t;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type func codes (instruction[5:0])
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALUctr encoding
  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SUBU = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

endpackage

// File: rtl/mc_control_decode.sv
// -----------------------------------------------------------------------------
// mc_decode
// Purely combinational instruction decoder: maps op/func to an instruction
// class plus the EX-stage datapath settings for that instruction.
// Ports:
//   i_op       in  6  opcode field
//   i_func     in  6  func field (only meaningful for R-type)
//   o_cls      out 3  instruction class (cls_t encoding)
//   o_aluctr   out 3  ALU operation for EX
//   o_ext_op   out 1  sign-extend the immediate in EX
//   o_alu_src  out 1  ALU B operand is the immediate in EX
//   o_ovf_chk  out 1  instruction is a trapping add/sub/addi
// -----------------------------------------------------------------------------
module mc_decode (
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output logic [2:0] o_cls,
  output logic [2:0] o_aluctr,
  output logic       o_ext_op,
  output logic       o_alu_src,
  output logic       o_ovf_chk
);
  import mc_control_pkg::*;

  always_comb begin
    o_cls     = C_ILL;
    o_aluctr  = ALU_ADDU;
    o_ext_op  = 1'b0;
    o_alu_src = 1'b0;
    o_ovf_chk = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_cls = C_RTYPE;
        case (i_func)
          FN_ADDU: o_aluctr = ALU_ADDU;
          FN_ADD: begin
            o_aluctr  = ALU_ADD;
            o_ovf_chk = 1'b1;
          end
          FN_SUBU: o_aluctr = ALU_SUBU;
          FN_SUB: begin
            o_aluctr  = ALU_SUB;
            o_ovf_chk = 1'b1;
          end
          FN_SLTU: o_aluctr = ALU_SLTU;
          FN_SLT:  o_aluctr = ALU_SLT;
          // Any other func (shifts, jr, ...) is not supported.
          default: o_cls = C_ILL;
        endcase
      end
      OP_ORI: begin
        // ori zero-extends its immediate
        o_cls     = C_IALU;
        o_aluctr  = ALU_OR;
        o_alu_src = 1'b1;
      end
      OP_ADDIU: begin
        o_cls     = C_IALU;
        o_aluctr  = ALU_ADDU;
        o_ext_op  = 1'b1;
        o_alu_src = 1'b1;
      end
      OP_ADDI: begin
        o_cls     = C_IALU;
        o_aluctr  = ALU_ADD;
        o_ext_op  = 1'b1;
        o_alu_src = 1'b1;
        o_ovf_chk = 1'b1;
      end
      OP_LW: begin
        o_cls     = C_LW;
        o_aluctr  = ALU_ADDU;
        o_ext_op  = 1'b1;
        o_alu_src = 1'b1;
      end
      OP_SW: begin
        o_cls     = C_SW;
        o_aluctr  = ALU_ADDU;
        o_ext_op  = 1'b1;
        o_alu_src = 1'b1;
      end
      OP_BEQ: begin
        o_cls    = C_BEQ;
        o_aluctr = ALU_SUBU;
      end
      OP_J: o_cls = C_J;
      default: o_cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// -----------------------------------------------------------------------------
// mc_control
// Multi-cycle control unit for a MIPS subset (addu/subu/add/sub/slt/sltu,
// ori/addiu/addi, lw/sw, beq, j). A five-state FSM (IF, ID, EX, MEM, WB)
// sequences the datapath; outputs are Moore functions of the state and the
// op/func latched in ID, except beq's PCWr/branch which also follow zero.
//
// Build option:
//   MC_CTRL_OVF_TRAP_EN  defined   -> overflow during EX of add/sub/addi
//                                     suppresses the WB write and sets the
//                                     sticky ovf_flag (cleared only by rst).
//                        undefined -> no trap; ovf_flag is tied to 0.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   op, func         instruction fields, valid in ID
//   zero, overflow   ALU flags, sampled in EX
//   PCWr, IRWr       PC update / IR load strobes
//   RegWr, MemWr     register file / memory write enables
//   ExtOp, ALUsrc, RegDst, MemtoReg, branch, jump   datapath selects
//   ALUctr           ALU operation (driven in EX, ADDU elsewhere)
//   state            current FSM state (debug)
//   instr_done       pulse on the final cycle of each instruction
//   illegal          pulse in ID for an unsupported op/func
//   ovf_flag         sticky overflow-trap flag
// -----------------------------------------------------------------------------
module mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       overflow,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWr,
  output logic       MemWr,
  output logic       ExtOp,
  output logic       ALUsrc,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       branch,
  output logic       jump,
  output logic [2:0] ALUctr,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       illegal,
  output logic       ovf_flag
);
  import mc_control_pkg::*;

  state_t     r_state;
  logic [5:0] r_op;
  logic [5:0] r_func;

  logic [5:0] w_dec_op;
  logic [5:0] w_dec_func;
  logic [2:0] w_cls_raw;
  cls_t       w_cls;
  logic [2:0] w_aluctr;
  logic       w_ext_op;
  logic       w_alu_src;
  logic       w_ovf_chk;
  logic       w_wb_suppress;

  // op/func are only valid while in ID, so ID decodes the live fields and
  // every later state decodes the copy captured at the end of ID.
  assign w_dec_op   = (r_state == S_ID) ? op   : r_op;
  assign w_dec_func = (r_state == S_ID) ? func : r_func;

  mc_decode u_decode (
    .i_op      (w_dec_op),
    .i_func    (w_dec_func),
    .o_cls     (w_cls_raw),
    .o_aluctr  (w_aluctr),
    .o_ext_op  (w_ext_op),
    .o_alu_src (w_alu_src),
    .o_ovf_chk (w_ovf_chk)
  );

  assign w_cls = cls_t'(w_cls_raw);

  // State register and op/func latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IF;
      r_op    <= 6'd0;
      r_func  <= 6'd0;
    end else begin
      case (r_state)
        S_IF: r_state <= S_ID;
        S_ID: begin
          r_op   <= op;
          r_func <= func;
          if (w_cls == C_ILL || w_cls == C_J) r_state <= S_IF;
          else                                r_state <= S_EX;
        end
        S_EX: begin
          case (w_cls)
            C_BEQ:      r_state <= S_IF;
            C_LW, C_SW: r_state <= S_MEM;
            default:    r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (w_cls == C_LW) r_state <= S_WB;
          else               r_state <= S_IF;
        end
        S_WB:    r_state <= S_IF;
        default: r_state <= S_IF;
      endcase
    end
  end

`ifdef MC_CTRL_OVF_TRAP_EN
  logic r_ovf_pend;
  logic r_ovf_flag;

  // r_ovf_pend is rewritten on every EX so it only ever refers to the
  // instruction currently heading into WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_pend <= 1'b0;
      r_ovf_flag <= 1'b0;
    end else if (r_state == S_EX) begin
      r_ovf_pend <= w_ovf_chk & overflow;
      if (w_ovf_chk && overflow) r_ovf_flag <= 1'b1;
    end
  end

  assign w_wb_suppress = r_ovf_pend;
  assign ovf_flag      = r_ovf_flag;
`else
  logic w_unused_ovf;
  assign w_unused_ovf  = overflow ^ w_ovf_chk;
  assign w_wb_suppress = 1'b0;
  assign ovf_flag      = 1'b0;
`endif

  // Moore output decode (beq PCWr/branch additionally follow zero)
  always_comb begin
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    RegWr      = 1'b0;
    MemWr      = 1'b0;
    ExtOp      = 1'b0;
    ALUsrc     = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    ALUctr     = ALU_ADDU;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_IF: begin
        IRWr = 1'b1;
        PCWr = 1'b1;
      end
      S_ID: begin
        if (w_cls == C_J) begin
          jump       = 1'b1;
          PCWr       = 1'b1;
          instr_done = 1'b1;
        end
        if (w_cls == C_ILL) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_EX: begin
        ALUctr = w_aluctr;
        ExtOp  = w_ext_op;
        ALUsrc = w_alu_src;
        if (w_cls == C_BEQ) begin
          branch     = zero;
          PCWr       = zero;
          instr_done = 1'b1;
        end
      end
      S_MEM: begin
        if (w_cls == C_SW) begin
          MemWr      = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_WB: begin
        RegWr      = ~w_wb_suppress;
        RegDst     = (w_cls == C_RTYPE);
        MemtoReg   = (w_cls == C_LW);
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_mc_control.sv
// -----------------------------------------------------------------------------
// tb_mc_control
// Drives instructions cycle by cycle; a behavioural model derives each
// cycle's expected outputs from the instruction class and pushes them to
// exp_q, and a negedge compare process checks the DUT against them.
// Directed literal checks pin cycle counts, state traces and reset behaviour.
// -----------------------------------------------------------------------------
module tb_mc_control;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, func;
  logic       zero, overflow;
  logic       PCWr, IRWr, RegWr, MemWr, ExtOp, ALUsrc, RegDst, MemtoReg;
  logic       branch, jump, instr_done, illegal, ovf_flag;
  logic [2:0] ALUctr, state;

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero),
    .overflow(overflow), .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr),
    .MemWr(MemWr), .ExtOp(ExtOp), .ALUsrc(ALUsrc), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .branch(branch), .jump(jump), .ALUctr(ALUctr),
    .state(state), .instr_done(instr_done), .illegal(illegal),
    .ovf_flag(ovf_flag)
  );

`ifdef MC_CTRL_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic pcwr, irwr, regwr, memwr, extop, alusrc, regdst, memtoreg, br, jmp;
    logic [2:0] alu;
    logic done, ill, ovf;
  } out_t;

  localparam int W = $bits(out_t);

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  int checks = 0;
  int errors = 0;

  // model state
  logic m_pend;
  logic m_sticky;

  localparam int K_R = 0, K_ORI = 1, K_ADDIU = 2, K_ADDI = 3, K_LW = 4,
                 K_SW = 5, K_BEQ = 6, K_J = 7, K_ILL = 8;

  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00: return (f == 6'h20 || f == 6'h21 || f == 6'h22 || f == 6'h23 ||
                     f == 6'h2A || f == 6'h2B) ? K_R : K_ILL;
      6'h0D: return K_ORI;
      6'h09: return K_ADDIU;
      6'h08: return K_ADDI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      case (f)
        6'h21: return 3'b000;
        6'h20: return 3'b001;
        6'h23: return 3'b100;
        6'h22: return 3'b101;
        6'h2B: return 3'b110;
        6'h2A: return 3'b111;
        default: return 3'b000;
      endcase
    end
    case (o)
      6'h0D: return 3'b010;
      6'h08: return 3'b001;
      6'h04: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int n_cycles(input int k);
    if (k == K_J || k == K_ILL) return 2;
    if (k == K_BEQ) return 3;
    if (k == K_LW) return 5;
    return 4;
  endfunction

  // state visited at a given step of an instruction of class k
  function automatic int state_at(input int k, input int step);
    if (step <= 2) return step;
    if (step == 3) return (k == K_LW || k == K_SW) ? 3 : 4;
    return 4;
  endfunction

  // ---------------- checks ----------------
  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e, m, a;
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      a = {state, PCWr, IRWr, RegWr, MemWr, ExtOp, ALUsrc, RegDst, MemtoReg,
           branch, jump, ALUctr, instr_done, illegal, ovf_flag};
      checks++;
      if (((a ^ e) & m) != '0) begin
        errors++;
        $display("FAIL outputs @%0t: got %h, expected %h (mask %h)", $time, a, e, m);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1 of an IF cycle; returns at posedge+1 of the cycle
  // after the last driven step. stop>0 truncates the instruction.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input logic z, input logic ov, input int stop,
                           output int done_at, output int trace);
    int   k, n, st;
    out_t e, m;
    k = classify(o, f);
    n = n_cycles(k);
    if (stop > 0 && stop < n) n = stop;
    done_at = 0;
    trace   = 0;
    for (int step = 0; step < n; step++) begin
      st       = state_at(k, step);
      op       = (st == 1) ? o : 6'($urandom_range(0, 63));
      func     = (st == 1) ? f : 6'($urandom_range(0, 63));
      zero     = (st == 2) ? z : 1'($urandom_range(0, 1));
      overflow = (st == 2) ? ov : 1'($urandom_range(0, 1));
      e = '0;
      m = '1;
      e.st  = 3'(st);
      e.ovf = m_sticky;
      case (st)
        0: begin e.irwr = 1'b1; e.pcwr = 1'b1; end
        1: begin
          if (k == K_J)   begin e.jmp = 1'b1; e.pcwr = 1'b1; e.done = 1'b1; end
          if (k == K_ILL) begin e.ill = 1'b1; e.done = 1'b1; end
        end
        2: begin
          e.alu    = alu_of(o, f);
          e.extop  = (k == K_ADDIU || k == K_ADDI || k == K_LW || k == K_SW);
          e.alusrc = (k == K_ORI || k == K_ADDIU || k == K_ADDI || k == K_LW || k == K_SW);
          if (!(k == K_ORI || k == K_ADDIU || k == K_ADDI || k == K_LW || k == K_SW))
            m.extop = 1'b0;
          if (k == K_BEQ) begin e.br = z; e.pcwr = z; e.done = 1'b1; end
        end
        3: if (k == K_SW) begin e.memwr = 1'b1; e.done = 1'b1; end
        default: begin
          e.regwr    = ~m_pend;
          e.regdst   = (k == K_R);
          e.memtoreg = (k == K_LW);
          e.done     = 1'b1;
        end
      endcase
      if (st != 2) begin
        m.alu    = 3'b000;
        m.extop  = 1'b0;
        m.alusrc = 1'b0;
      end
      exp_q.push_back(e);
      msk_q.push_back(m);
      @(negedge clk);
      trace = trace * 8 + int'(state);
      if (instr_done && done_at == 0) done_at = step + 1;
      if (st == 2) begin
        m_pend = TRAP && ov && (k == K_ADDI || (k == K_R && (f == 6'h20 || f == 6'h22)));
        if (m_pend) m_sticky = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    m_pend   = 1'b0;
    m_sticky = 1'b0;
    #1;
    check_int("rst_pulse_state", int'(state), 0);
    check_int("rst_pulse_ovf", int'(ovf_flag), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic [5:0] fn_tab [6] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B};
  logic [5:0] op_tab [7] = '{6'h0D, 6'h09, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};

  initial begin
    int d, t, sel;
    logic [5:0] o, f;
    rst = 1'b1; op = 6'd0; func = 6'd0; zero = 1'b0; overflow = 1'b0;
    m_pend = 1'b0; m_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_int("reset_state", int'(state), 0);
    check_int("reset_irwr", int'(IRWr), 1);
    check_int("reset_pcwr", int'(PCWr), 1);
    check_int("reset_quiet", int'({RegWr, MemWr, instr_done, illegal, jump, branch}), 0);
    check_int("reset_ovf", int'(ovf_flag), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // add: IF,ID,EX,WB -> trace octal 0124
    run_instr(6'h00, 6'h20, 1'b0, 1'b0, 0, d, t);
    check_int("add_cycles", d, 4);
    check_int("add_trace", t, 84);
    // lw: octal 01234
    run_instr(6'h23, 6'h15, 1'b0, 1'b0, 0, d, t);
    check_int("lw_cycles", d, 5);
    check_int("lw_trace", t, 668);
    // beq taken / not taken: octal 012
    run_instr(6'h04, 6'h00, 1'b1, 1'b0, 0, d, t);
    check_int("beq_t_cycles", d, 3);
    check_int("beq_t_trace", t, 10);
    run_instr(6'h04, 6'h00, 1'b0, 1'b0, 0, d, t);
    check_int("beq_nt_cycles", d, 3);
    // j and illegal: octal 01
    run_instr(6'h02, 6'h00, 1'b0, 1'b0, 0, d, t);
    check_int("j_cycles", d, 2);
    check_int("j_trace", t, 1);
    run_instr(6'h3F, 6'h00, 1'b0, 1'b0, 0, d, t);
    check_int("illegal_cycles", d, 2);
    check_int("illegal_trace", t, 1);
    // sw: octal 0123
    run_instr(6'h2B, 6'h07, 1'b0, 1'b0, 0, d, t);
    check_int("sw_cycles", d, 4);
    check_int("sw_trace", t, 83);

    // sw interrupted by rst in EX
    run_instr(6'h2B, 6'h00, 1'b0, 1'b0, 2, d, t);
    check_int("sw_at_ex", int'(state), 2);
    check_int("sw_ex_memwr", int'(MemWr), 0);
    #1;
    rst = 1'b1;
    m_pend = 1'b0; m_sticky = 1'b0;
    #1;
    check_int("async_rst_state", int'(state), 0);
    check_int("async_rst_memwr", int'(MemWr), 0);
    check_int("async_rst_irwr", int'(IRWr), 1);
    @(posedge clk);
    #1;
    check_int("held_rst_state", int'(state), 0);
    check_int("held_rst_memwr", int'(MemWr), 0);
    rst = 1'b0;
    run_instr(6'h00, 6'h21, 1'b0, 1'b0, 0, d, t);
    check_int("after_rst_addu", d, 4);

    // overflow on add, then a clean addu: flag is sticky in the trap build
    run_instr(6'h00, 6'h20, 1'b0, 1'b1, 0, d, t);
    check_int("ovf_flag_set", int'(ovf_flag), TRAP ? 1 : 0);
    run_instr(6'h00, 6'h21, 1'b0, 1'b0, 0, d, t);
    check_int("ovf_flag_sticky", int'(ovf_flag), TRAP ? 1 : 0);
    reset_pulse();

    // randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3) begin
        o = 6'h00;
        f = fn_tab[$urandom_range(0, 5)];
      end else if (sel < 9) begin
        o = op_tab[$urandom_range(0, 6)];
        f = 6'($urandom_range(0, 63));
      end else begin
        o = 6'($urandom_range(0, 63));
        f = 6'($urandom_range(0, 63));
      end
      run_instr(o, f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, d, t);
      check_int("rand_cpi", d, n_cycles(classify(o, f)));
      if ($urandom_range(0, 49) == 0) reset_pulse();
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Reset is asynchronous and active-high; single clock.
REQ-002 clk  in  1  system clock, rising-edge active.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 op  in  6  instruction[31:26] from datapath; valid only in ID.
REQ-005 func  in  6  instruction[5:0] from datapath; valid only in ID.
REQ-006 zero  in  1  ALU zero flag; sampled in EX.
REQ-007 overflow  in  1  ALU overflow flag; sampled in EX.
REQ-008 PCWr, IRWr  out  1 each  PC update / instruction-register load strobes.
REQ-009 RegWr, MemWr  out  1 each  register-file / memory write enables.
REQ-010 ExtOp, ALUsrc, RegDst, MemtoReg, branch, jump  out  1 each  datapath selects, same meaning as the datapath control inputs.
REQ-011 ALUctr  out  3  ALU operation.
REQ-012 state  out  3  current FSM state, for debug.
REQ-013 instr_done  out  1  one-cycle pulse on an instruction's final cycle.
REQ-014 illegal  out  1  one-cycle pulse when ID decodes an unsupported op/func.

Function
REQ-015 FSM states SHALL be IF=0, ID=1, EX=2, MEM=3, WB=4; no other state is reachable.
REQ-016 IF: assert IRWr and PCWr (PC+4); next state is ID.
REQ-017 ID: latch op/func into internal registers; a legal opcode goes to EX; j asserts jump and PCWr, pulses instr_done, and returns to IF.
REQ-018 An illegal op/func in ID SHALL pulse illegal and instr_done, write nothing, and return to IF.
REQ-019 Supported instructions: R-type addu, subu, add, sub, slt, sltu, plus ori, addiu, addi, lw, sw, beq, j.
REQ-020 EX, beq: ALUctr=SUBU; branch=1 and PCWr=1 only if zero=1; instr_done=1; next state is IF.
REQ-021 EX, lw/sw: ALUsrc=1, ExtOp=1, ALUctr=ADDU; next state is MEM.
REQ-022 EX, R-type/ori/addiu/addi: next state is WB; the ALU result is held by the datapath.
REQ-023 MEM, sw: MemWr=1, instr_done=1, next state is IF; MEM, lw: next state is WB.
REQ-024 WB: RegWr=1; RegDst=1 for R-type, else 0; MemtoReg=1 only for lw; instr_done=1; next state is IF.
REQ-025 ExtOp=0 for ori and 1 for addiu/addi/lw/sw; ALUsrc=1 for all I-type ALU operations.
REQ-026 All outputs SHALL be combinational functions of the state and the latched op/func (Moore), except the beq PCWr/branch pair, which also depends on zero.
REQ-027 Cycles per instruction: j=2, beq=3, R-type/ALU-I=4, sw=4, lw=5.
REQ-028 ALUctr encoding: ADDU=000, ADD=001, OR=010, SUBU=100, SUB=101, SLTU=110, SLT=111.
REQ-029 Strobes SHALL be deasserted outside the states listed above; at most one of RegWr/MemWr is asserted per cycle.

Reset
REQ-030 rst SHALL force state=IF and clear the latched op/func to 0 immediately, including mid-instruction; no write strobe may fire during rst.
REQ-031 After rst falls, the first rising edge SHALL execute IF.
REQ-032 Output values while in reset: IRWr=1, PCWr=1 (IF decode), all other strobes 0, illegal=0, instr_done=0.

Configuration
REQ-033 Macro MC_CTRL_OVF_TRAP_EN.
REQ-034 Defined: overflow=1 in EX for add/sub/addi SHALL be latched, and the following WB SHALL suppress RegWr; the sticky output ovf_flag (out, 1 bit) is cleared only by rst.
REQ-035 Undefined: add/sub/addi SHALL write back regardless of overflow; the ovf_flag port SHALL be present and tied to 0.

Structure
REQ-036 A shared package SHALL hold the state encoding, the opcode/func constants, and the ALUctr encoding.
REQ-037 A combinational sub-module mc_decode SHALL map the latched op/func to an instruction class and ALUctr.

Verification
REQ-038 Reset, then add (op=0, func=0x20): states IF,ID,EX,WB; RegWr=1 and RegDst=1 in WB only; instr_done in cycle 4.
REQ-039 lw (op=0x23): 5 cycles; MEM then WB with MemtoReg=1, RegWr=1; ExtOp=1 and ALUsrc=1 in EX.
REQ-040 beq (op=0x04) with zero=1: PCWr=1 and branch=1 in EX; with zero=0: PCWr=0; both cases return to IF after 3 cycles.
REQ-041 op=0x3F: illegal pulses in ID; no RegWr or MemWr; next state is IF.
REQ-042 rst asserted during sw EX: state=IF asynchronously; MemWr never asserted.
REQ-043 With MC_CTRL_OVF_TRAP_EN defined, add with overflow=1: RegWr=0 in WB and ovf_flag=1 until rst.
